// File: rtl/alu_adder_pkg.sv
// Shared types for the sequential carry-select adder/subtractor.
package alu_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice index width: clog2 of the slice count, never narrower than one bit.
    function automatic int idx_width(input int k);
        int w;
        if (k > 1) begin
            w = $clog2(k);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/alu_adder_cs_slice.sv
// Combinational carry-select slice: both carry cases precomputed, late carry picks one.
module alu_adder_cs_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         sum_msb
);

    logic [N-1:0] sum0_s;
    logic [N-1:0] sum1_s;
    logic         co0_s;
    logic         co1_s;

    full_adder #(.N(N)) u_fa_c0 (
        .a    (a),
        .b    (b),
        .cin  (1'b0),
        .sum  (sum0_s),
        .cout (co0_s)
    );

    full_adder #(.N(N)) u_fa_c1 (
        .a    (a),
        .b    (b),
        .cin  (1'b1),
        .sum  (sum1_s),
        .cout (co1_s)
    );

    // Select the precomputed result matching the incoming carry.
    always_comb begin
        if (carry_in) begin
            sum       = sum1_s;
            carry_out = co1_s;
        end else begin
            sum       = sum0_s;
            carry_out = co0_s;
        end
        sum_msb = sum[N-1];
    end

endmodule

// File: rtl/full_adder.sv
// N-bit ripple full adder with carry in and carry out.
module full_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/alu_adder_cs_seq.sv
// Multi-cycle carry-select adder/subtractor resolving one SLICE-bit chunk per clock.
import alu_adder_pkg::*;

module alu_adder_cs_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    input  logic             enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int K  = WIDTH / SLICE;
    localparam int IW = idx_width(K);
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             en_q,     en_d;
    logic             carry_q,  carry_d;
    logic [IW-1:0]    idx_q,    idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             co_q,     co_d;
    logic             ov_q,     ov_d;

    int               base_s;
    logic [SLICE-1:0] slice_sum_s;
    logic             slice_co_s;
    logic             slice_msb_s;

    assign base_s = int'(idx_q) * SLICE;

    alu_adder_cs_slice #(.N(SLICE)) u_slice (
        .a         (a_q[base_s +: SLICE]),
        .b         (b_q[base_s +: SLICE]),
        .carry_in  (carry_q),
        .sum       (slice_sum_s),
        .carry_out (slice_co_s),
        .sum_msb   (slice_msb_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        en_d     = en_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        co_d     = co_q;
        ov_d     = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = sub ? ~b : b;
                    en_d     = enable;
                    carry_d  = sub ? 1'b1 : carry_in;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                result_d[base_s +: SLICE] = en_q ? slice_sum_s : {SLICE{1'b0}};
                carry_d = slice_co_s;
                if (idx_q == LAST_IDX) begin
                    co_d    = slice_co_s;
                    // Overflow uses the true sum MSB, independent of enable.
                    ov_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_msb_s != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            en_q     <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            en_q     <= en_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            co_q     <= co_d;
            ov_q     <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;

endmodule
